// File: rtl/set_assoc_cache_ctrl.sv
// 2-way, 8-set read-only cache controller with per-set LRU replacement and line refill from memory.
// Defining CACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module set_assoc_cache_ctrl #(
    parameter int STAT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [11:0]  req_addr,
    input  logic         flush,
    output logic         resp_valid,
    output logic         resp_hit,
    output logic [127:0] resp_line,
    output logic [7:0]   resp_byte,
    output logic         mem_req,
    output logic [7:0]   mem_addr,
    input  logic         mem_valid,
    input  logic [127:0] mem_line
`ifdef CACHE_STATS_EN
    ,
    output logic [STAT_W-1:0] hit_count,
    output logic [STAT_W-1:0] miss_count
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOOKUP   = 2'd1,
        MEM_WAIT = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t       state_r;
    state_t       state_s;
    logic [11:0]  addr_r;
    logic [1:0]   valid_r [8];
    logic [7:0]   lru_r;
    logic [4:0]   tag_mem  [2][8];
    logic [127:0] line_mem [2][8];

    logic [2:0]   set_s;
    logic [4:0]   tag_s;
    logic [3:0]   off_s;
    logic         hit0_s;
    logic         hit1_s;
    logic         hit_s;
    logic         victim_s;
    logic [127:0] hit_line_s;

    function automatic logic [7:0] byte_sel(input logic [127:0] line, input logic [3:0] off);
        return line[{off, 3'b000} +: 8];
    endfunction

    assign set_s = addr_r[6:4];
    assign tag_s = addr_r[11:7];
    assign off_s = addr_r[3:0];

    assign req_ready = (state_r == IDLE) && !flush;

    // Tag compare, hit line select and victim choice for the latched set.
    always_comb begin
        hit0_s     = valid_r[set_s][0] && (tag_mem[0][set_s] == tag_s);
        hit1_s     = valid_r[set_s][1] && (tag_mem[1][set_s] == tag_s);
        hit_s      = hit0_s || hit1_s;
        hit_line_s = hit1_s ? line_mem[1][set_s] : line_mem[0][set_s];
        if (!valid_r[set_s][0]) begin
            victim_s = 1'b0;
        end else if (!valid_r[set_s][1]) begin
            victim_s = 1'b1;
        end else begin
            victim_s = lru_r[set_s];
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid && !flush) begin
                    state_s = LOOKUP;
                end else begin
                    state_s = IDLE;
                end
            end
            LOOKUP: begin
                if (hit_s) begin
                    state_s = RESP;
                end else begin
                    state_s = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_valid) begin
                    state_s = RESP;
                end else begin
                    state_s = MEM_WAIT;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request latch, valid/LRU bookkeeping and registered response/memory outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_r     <= 12'h000;
            lru_r      <= 8'h00;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_line  <= 128'h0;
            resp_byte  <= 8'h00;
            mem_req    <= 1'b0;
            mem_addr   <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                valid_r[i] <= 2'b00;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (flush) begin
                        lru_r <= 8'h00;
                        for (int i = 0; i < 8; i++) begin
                            valid_r[i] <= 2'b00;
                        end
                    end else if (req_valid) begin
                        addr_r <= req_addr;
                    end
                end
                LOOKUP: begin
                    if (hit_s) begin
                        // LRU bit names the way to evict next: the one not just used.
                        lru_r[set_s] <= ~hit1_s;
                        resp_valid   <= 1'b1;
                        resp_hit     <= 1'b1;
                        resp_line    <= hit_line_s;
                        resp_byte    <= byte_sel(hit_line_s, off_s);
                    end else begin
                        mem_req  <= 1'b1;
                        mem_addr <= addr_r[11:4];
                    end
                end
                MEM_WAIT: begin
                    if (mem_valid) begin
                        valid_r[set_s][victim_s] <= 1'b1;
                        lru_r[set_s]             <= ~victim_s;
                        mem_req                  <= 1'b0;
                        resp_valid               <= 1'b1;
                        resp_hit                 <= 1'b0;
                        resp_line                <= mem_line;
                        resp_byte                <= byte_sel(mem_line, off_s);
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                end
                default: begin
                    resp_valid <= 1'b0;
                    mem_req    <= 1'b0;
                end
            endcase
        end
    end

    // Tag and line storage; contents are qualified by valid_r so they are never reset.
    always_ff @(posedge clk) begin
        if (rst_n && (state_r == MEM_WAIT) && mem_valid) begin
            tag_mem[victim_s][set_s]  <= tag_s;
            line_mem[victim_s][set_s] <= mem_line;
        end
    end

`ifdef CACHE_STATS_EN
    // Saturating lookup statistics.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_count  <= {STAT_W{1'b0}};
            miss_count <= {STAT_W{1'b0}};
        end else if (state_r == LOOKUP) begin
            if (hit_s) begin
                if (hit_count != {STAT_W{1'b1}}) begin
                    hit_count <= hit_count + {{(STAT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                if (miss_count != {STAT_W{1'b1}}) begin
                    miss_count <= miss_count + {{(STAT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Bench for set_assoc_cache_ctrl: directed vector table, flush/reset sequences and
// random reads checked against a recency-ordered set model.
module tb_set_assoc_cache_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [11:0]  req_addr;
    logic         flush;
    logic         resp_valid;
    logic         resp_hit;
    logic [127:0] resp_line;
    logic [7:0]   resp_byte;
    logic         mem_req;
    logic [7:0]   mem_addr;
    logic         mem_valid;
    logic [127:0] mem_line;
`ifdef CACHE_STATS_EN
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;
`endif

    set_assoc_cache_ctrl #(.STAT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .flush(flush), .resp_valid(resp_valid), .resp_hit(resp_hit),
        .resp_line(resp_line), .resp_byte(resp_byte), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_valid(mem_valid), .mem_line(mem_line)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: per set, up to two tags ordered LRU (index 0) to MRU (index cnt-1).
    int         m_cnt [8];
    logic [4:0] m_ord [8][2];
    int         m_hits = 0;
    int         m_misses = 0;

    typedef struct {
        logic [11:0] addr;
        logic        exp_hit;
        int          lat;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [127:0] mem_data(input logic [7:0] la);
        logic [127:0] d;
        for (int i = 0; i < 16; i++) d[8*i +: 8] = la ^ 8'(i * 29 + 7);
        return d;
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < 8; s++) m_cnt[s] = 0;
    endfunction

    function automatic bit model_access(input logic [11:0] a);
        int s = int'(a[6:4]);
        logic [4:0] t = a[11:7];
        for (int k = 0; k < m_cnt[s]; k++) begin
            if (m_ord[s][k] == t) begin
                if (m_cnt[s] == 2 && k == 0) begin
                    m_ord[s][0] = m_ord[s][1];
                    m_ord[s][1] = t;
                end
                m_hits++;
                return 1'b1;
            end
        end
        if (m_cnt[s] < 2) begin
            m_ord[s][m_cnt[s]] = t;
            m_cnt[s]++;
        end else begin
            m_ord[s][0] = m_ord[s][1];
            m_ord[s][1] = t;
        end
        m_misses++;
        return 1'b0;
    endfunction

    // Issues one read starting at a negedge in IDLE; ends at a negedge back in IDLE.
    task automatic do_read(input logic [11:0] a, input logic exp_hit, input int lat);
        int n = 1;
        int waited = 0;
        bit got = 1'b0;
        bit seen_mem = 1'b0;
        logic [127:0] exp_line = mem_data(a[11:4]);
        req_valid = 1'b1;
        req_addr  = a;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 12'($urandom);
        mem_valid = 1'($urandom_range(0, 1));
        mem_line  = ~exp_line;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            mem_valid = 1'b0;
            if (resp_valid) begin
                got = 1'b1;
                chk("resp_hit", 128'(resp_hit), 128'(exp_hit));
                chk("resp_line", resp_line, exp_line);
                chk("resp_byte", 128'(resp_byte), 128'(exp_line[8*a[3:0] +: 8]));
                chk("mem_req_excl", 128'(mem_req), 128'h0);
                chk("mem_req_seen", 128'(seen_mem), 128'(!exp_hit));
                if (exp_hit) chk("hit_latency", 128'(n), 128'd2);
            end else if (mem_req) begin
                seen_mem = 1'b1;
                chk("mem_addr", 128'(mem_addr), 128'(a[11:4]));
                if (waited >= lat) begin
                    mem_valid = 1'b1;
                    mem_line  = exp_line;
                end else begin
                    waited++;
                end
            end
        end
        if (!got) chk("resp_timeout", 128'h0, 128'h1);
        @(negedge clk);
        chk("resp_one_cycle", 128'(resp_valid), 128'h0);
        chk("idle_ready", 128'(req_ready), 128'h1);
    endtask

    task automatic do_flush(input logic with_req, input logic [11:0] a);
        flush     = 1'b1;
        req_valid = with_req;
        req_addr  = a;
        #1;
        chk("flush_ready", 128'(req_ready), 128'h0);
        @(posedge clk);
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        model_clear();
        @(negedge clk);
        chk("flush_no_accept", 128'({mem_req, resp_valid}), 128'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        m_hits   = 0;
        m_misses = 0;
    endtask

    initial begin
        bit quiet;
        rst_n = 1'b0; req_valid = 1'b0; req_addr = 12'h000; flush = 1'b0;
        mem_valid = 1'b0; mem_line = 128'h0;

        vecs[0] = '{addr: 12'hFF0, exp_hit: 1'b0, lat: 2};
        vecs[1] = '{addr: 12'hFF5, exp_hit: 1'b1, lat: 0};
        vecs[2] = '{addr: 12'h010, exp_hit: 1'b0, lat: 0};
        vecs[3] = '{addr: 12'h090, exp_hit: 1'b0, lat: 1};
        vecs[4] = '{addr: 12'h01A, exp_hit: 1'b1, lat: 0};
        vecs[5] = '{addr: 12'h110, exp_hit: 1'b0, lat: 3};
        vecs[6] = '{addr: 12'h01F, exp_hit: 1'b1, lat: 0};
        vecs[7] = '{addr: 12'h093, exp_hit: 1'b0, lat: 0};

        @(negedge clk);
        do_reset();
        chk("rst_resp_valid", 128'(resp_valid), 128'h0);
        chk("rst_resp_hit", 128'(resp_hit), 128'h0);
        chk("rst_mem_req", 128'(mem_req), 128'h0);
        chk("rst_mem_addr", 128'(mem_addr), 128'h0);
        chk("rst_resp_line", resp_line, 128'h0);
        chk("rst_resp_byte", 128'(resp_byte), 128'h0);
        chk("rst_req_ready", 128'(req_ready), 128'h1);

        for (int i = 0; i < 8; i++) begin
            void'(model_access(vecs[i].addr));
            do_read(vecs[i].addr, vecs[i].exp_hit, vecs[i].lat);
`ifdef CACHE_STATS_EN
            if (i == 1) begin
                chk("stat_hits", 128'(hit_count), 128'd1);
                chk("stat_misses", 128'(miss_count), 128'd1);
            end
`endif
        end

        // Flush wins over a simultaneous request; the line then misses.
        do_flush(1'b1, 12'hFF0);
        void'(model_access(12'hFF0));
        do_read(12'hFF0, 1'b0, 1);

        // Reset while waiting on memory abandons the request.
        void'(model_access(12'h7A0));
        req_valid = 1'b1;
        req_addr  = 12'h7A0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("mw_mem_req", 128'(mem_req), 128'h1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mw_rst_mem_req", 128'(mem_req), 128'h0);
        rst_n = 1'b1;
        model_clear();
        m_hits = 0;
        m_misses = 0;
        mem_valid = 1'b1;
        mem_line  = mem_data(8'h7A);
        @(negedge clk);
        mem_valid = 1'b0;
        quiet = 1'b1;
        repeat (4) begin
            if (resp_valid || mem_req) quiet = 1'b0;
            @(negedge clk);
        end
        chk("mw_late_mem_valid", 128'(quiet), 128'h1);
        void'(model_access(12'h7A0));
        do_read(12'h7A0, 1'b0, 0);

        for (int r = 0; r < 150; r++) begin
            if ($urandom_range(0, 19) == 0) begin
                do_flush(1'($urandom_range(0, 1)), 12'($urandom));
            end else begin
                logic [11:0] a;
                logic        h;
                a = {3'($urandom_range(0, 3)), 2'b00, 3'($urandom), 4'($urandom)};
                h = model_access(a);
                do_read(a, h, $urandom_range(0, 3));
            end
        end
`ifdef CACHE_STATS_EN
        chk("stat_hits_rand", 128'(hit_count), 128'(m_hits));
        chk("stat_misses_rand", 128'(miss_count), 128'(m_misses));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/set_assoc_cache_ctrl.md
SET_ASSOC_CACHE_CTRL -- requirements
Module: set_assoc_cache_ctrl

Interface
REQ-001 SHALL provide parameter: STAT_W, 16, width of the statistics counters.
REQ-002 SHALL provide ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  CPU read request.
- req_ready  output  1  controller can accept a request.
- req_addr  input  12  byte address: tag [11:7], set [6:4], offset [3:0].
- flush  input  1  invalidate entire cache.
- resp_valid  output  1  response strobe.
- resp_hit  output  1  1 = served from cache, 0 = served by refill.
- resp_line  output  128  addressed 16-byte line.
- resp_byte  output  8  addressed byte.
- mem_req  output  1  line read request to main memory.
- mem_addr  output  8  memory line address {tag,set}.
- mem_valid  input  1  memory line returned.
- mem_line  input  128  returned line.
REQ-003 SHALL use one clock, clk; reset rst_n is synchronous and active-low.

Function
REQ-004 SHALL implement 2-way set-associative storage: 8 sets x 2 ways, each way holding valid bit, 5-bit tag and 128-bit line; one LRU bit per set.
REQ-005 SHALL implement FSM states IDLE, LOOKUP, MEM_WAIT, RESP.
REQ-006 SHALL drive req_ready = 1 only in IDLE with flush = 0.
REQ-007 SHALL accept a request on a rising edge with req_valid & req_ready, latch req_addr, and go IDLE -> LOOKUP.
REQ-008 SHALL in LOOKUP compare the latched tag against both valid ways of the set; hit -> RESP with resp_hit = 1; miss -> MEM_WAIT.
REQ-009 SHALL give hit latency: resp_valid high in the second cycle after the accept edge.
REQ-010 SHALL in MEM_WAIT hold mem_req = 1 and mem_addr = latched addr[11:4] until mem_valid is sampled high.
REQ-011 SHALL on that edge write mem_line, tag and valid = 1 into the victim way, then go to RESP with resp_hit = 0 and mem_req = 0 in the next cycle.
REQ-012 SHALL choose the victim as follows: way0 if invalid; else way1 if invalid; else the way indicated by the set's LRU bit.
REQ-013 SHALL on a hit or a fill set the LRU bit to point to the way not just used.
REQ-014 SHALL in RESP assert resp_valid for exactly one cycle, then return to IDLE.
REQ-015 SHALL hold resp_line, resp_byte and resp_hit valid while resp_valid = 1.
REQ-016 SHALL set resp_byte = resp_line[8*offset+7 : 8*offset], with byte 0 at bits [7:0].
REQ-017 SHALL ignore mem_valid outside MEM_WAIT.
REQ-018 SHALL ignore req_valid outside IDLE.
REQ-019 SHALL handle flush only in IDLE: it clears all valid and LRU bits in one cycle and wins over a simultaneous req_valid, with no request accepted that cycle.
REQ-020 SHALL ignore flush in other states.
REQ-021 SHALL keep resp_valid and mem_req mutually exclusive and low in IDLE.

Reset
REQ-022 SHALL on rst_n = 0 at a clock edge:
- go to IDLE;
- clear all valid and LRU bits;
- drive resp_valid, resp_hit, mem_req = 0, resp_line = 0, resp_byte = 0, mem_addr = 0;
- clear the counters.
REQ-023 SHALL NOT reset the tag and line arrays.
REQ-024 SHALL, when reset occurs mid-operation in any state, abandon the request with no resp_valid; mem_req is low from the next cycle; a late mem_valid is ignored.

Configuration
REQ-025 SHALL, with macro CACHE_STATS_EN defined, add outputs hit_count and miss_count (STAT_W each).
REQ-026 SHALL, with CACHE_STATS_EN defined, increment hit_count on a LOOKUP hit and miss_count on a LOOKUP miss, each saturating at all-ones.
REQ-027 SHALL, without CACHE_STATS_EN, omit both ports and the counter logic; all other behaviour is identical.

Verification
REQ-028 SHALL cover these directed scenarios:
- Cold miss: after reset, read 0xFF0 -> mem_req with mem_addr = 0xFF; return line L -> resp_valid, resp_hit = 0, resp_line = L, resp_byte = L[7:0].
- Hit: then read 0xFF5 -> no mem_req; resp_valid in the second cycle after accept; resp_hit = 1; resp_byte = L[47:40].
- LRU eviction (set 1): read 0x010, 0x090 (two misses), 0x010 (hit), 0x110 (miss, evicts 0x090's way), 0x010 (hit), 0x090 (miss).
- Flush: flush = 1 together with req_valid in IDLE -> req_ready = 0 and request not accepted; afterwards read 0xFF0 -> miss.
- Reset in MEM_WAIT: rst_n low while mem_req = 1 -> mem_req = 0 next cycle; mem_valid pulse afterwards ignored; no resp_valid.
- Stats, with CACHE_STATS_EN: after the cold-miss and hit scenarios -> hit_count = 1, miss_count = 1.
